// File: rtl/huffman_pkg.sv
// Shared types and widths for the Huffman bit packer.
package huffman_pkg;

    localparam int C_ACC_W  = 64;
    localparam int C_WORD_W = 32;
    localparam int C_CNT_W  = 7;
    localparam int C_WCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        REQ,
        GAP
    } wo_state_e;

endpackage

// File: rtl/huffman_word_out.sv
// Output word register, rfifo write FSM and acknowledged-word counter.
module huffman_word_out
    import huffman_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_req,
    input  logic [C_WORD_W-1:0] acc_top,
    input  logic                rfifo_full,
    input  logic                wrack,
    output logic                load_fire,
    output logic                idle,
    output logic                wrreq,
    output logic [0:C_WORD_W-1] data,
    output logic [C_WCNT_W-1:0] words_out
);

    wo_state_e           state_q, state_d;
    logic [0:C_WORD_W-1] out_q, out_d;
    logic [C_WCNT_W-1:0] words_q, words_d;
    logic                wrreq_q, wrreq_d;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        words_d   = words_q;
        load_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                // full is only sampled here; an issued request is never withdrawn
                if (load_req && !rfifo_full) begin
                    load_fire = 1'b1;
                    out_d     = acc_top;
                    state_d   = LOAD;
                end
            end
            LOAD: state_d = REQ;
            REQ: begin
                if (wrack) begin
                    words_d = words_q + 1'b1;
                    state_d = GAP;
                end
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wrreq_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            words_q <= '0;
            wrreq_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            words_q <= words_d;
            wrreq_q <= wrreq_d;
        end
    end

    assign idle      = (state_q == IDLE);
    assign wrreq     = wrreq_q;
    assign data      = out_q;
    assign words_out = words_q;

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs MSB-first variable-length codes into 32-bit rfifo words;
// sym_last flushes the final partial word zero-padded.
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int C_RDFIFO_DWIDTH = 32,
    parameter int C_MAX_LEN       = 16,
    parameter int C_LEN_W         = 5
) (
    input  logic                       bus2ip_clk,
    input  logic                       bus2ip_resetn,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic [0:C_MAX_LEN-1]       sym_code,
    input  logic [0:C_LEN_W-1]         sym_len,
    input  logic                       sym_last,
    output logic                       ip2rfifo_wrreq,
    output logic [0:C_RDFIFO_DWIDTH-1] ip2rfifo_data,
    input  logic                       rfifo2ip_wrack,
    input  logic                       rfifo2ip_full,
    output logic [15:0]                words_out,
    output logic                       flush_done
);

    logic [C_ACC_W-1:0] acc_q, acc_d, acc_s, code_m;
    logic [C_CNT_W-1:0] cnt_q, cnt_d, cnt_s, shamt;
    logic [C_LEN_W-1:0] len_eff;
    logic               flush_pending_q, flush_pending_d;
    logic               flush_done_q, flush_done_d;
    logic               sym_fire, load_req, load_fire, idle, flush_fire;

    assign sym_ready = (cnt_q <= C_CNT_W'(C_ACC_W - C_MAX_LEN))
                       && !flush_pending_q;
    assign sym_fire   = sym_valid && sym_ready;
    assign load_req   = (cnt_q >= C_CNT_W'(C_WORD_W))
                        || (flush_pending_q && cnt_q != '0);
    assign flush_fire = idle && flush_pending_q && (cnt_q == '0);
    assign flush_done = flush_done_q;

    always_comb begin
        len_eff = (sym_len > C_LEN_W'(C_MAX_LEN)) ? C_LEN_W'(C_MAX_LEN) : sym_len;
        code_m  = C_ACC_W'(sym_code)
                  & ((C_ACC_W'(1) << len_eff) - C_ACC_W'(1));
        acc_s = acc_q;
        cnt_s = cnt_q;
        // shift-out happens before the append on a shared edge
        if (load_fire) begin
            acc_s = acc_q << C_WORD_W;
            cnt_s = (cnt_q >= C_CNT_W'(C_WORD_W)) ? cnt_q - C_CNT_W'(C_WORD_W) : '0;
        end
        shamt = C_CNT_W'(C_ACC_W) - cnt_s - C_CNT_W'(len_eff);
        acc_d = acc_s;
        cnt_d = cnt_s;
        if (sym_fire) begin
            acc_d = acc_s | (code_m << shamt);
            cnt_d = cnt_s + C_CNT_W'(len_eff);
        end
        flush_pending_d = flush_pending_q;
        if (flush_fire) flush_pending_d = 1'b0;
        if (sym_fire && sym_last) flush_pending_d = 1'b1;
        flush_done_d = flush_fire;
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_resetn) begin
        if (!bus2ip_resetn) begin
            acc_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
        end
    end

    huffman_word_out u_word_out (
        .clk        (bus2ip_clk),
        .rst_n      (bus2ip_resetn),
        .load_req   (load_req),
        .acc_top    (acc_q[C_ACC_W-1 -: C_WORD_W]),
        .rfifo_full (rfifo2ip_full),
        .wrack      (rfifo2ip_wrack),
        .load_fire  (load_fire),
        .idle       (idle),
        .wrreq      (ip2rfifo_wrreq),
        .data       (ip2rfifo_data),
        .words_out  (words_out)
    );

endmodule
